// File: rtl/estacao_enchimento_pkg.sv
// Shared constants for the filling station: state encodings, default fill
// timeout and the state-to-output decode used by the FSM.
package estacao_enchimento_pkg;

    typedef enum logic [2:0] {
        PARADO    = 3'd0,
        ESTEIRA   = 3'd1,
        ENCHENDO  = 3'd2,
        TRANSFERE = 3'd3,
        ERRO      = 3'd4
    } estado_t;

    localparam int FILL_TIMEOUT_DEFAULT = 100;

    // Output order: {motor, valvula, gar_pronta, alarme_enchimento}
    function automatic logic [3:0] decodifica(input estado_t estado);
        logic [3:0] saidas;
        saidas = 4'b0000;
        case (estado)
            ESTEIRA:   saidas = 4'b1000;
            ENCHENDO:  saidas = 4'b0100;
            TRANSFERE: saidas = 4'b0010;
            ERRO:      saidas = 4'b0001;
            default:   saidas = 4'b0000;
        endcase
        return saidas;
    endfunction

endpackage

// File: rtl/estacao_enchimento_sincronizador.sv
// Two-flop synchronizer bringing an asynchronous sensor into the clk domain.
module sincronizador (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/estacao_enchimento.sv
// Bottle filling station: conveyor, fill valve with timeout, and hand-off of
// filled bottles to the capping stage.
module estacao_enchimento
    import estacao_enchimento_pkg::*;
#(
    parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sensor_garrafa,
    input  logic       sensor_nivel,
    input  logic       done_vedacao,
    input  logic       alarme_vedacao,
    output logic       motor,
    output logic       valvula,
    output logic       gar_pronta,
    output logic       alarme_enchimento,
    output logic [7:0] garrafas_cheias
);

    localparam logic [7:0] TIMER_MAX = 8'(FILL_TIMEOUT - 1);

    estado_t    estado;
    estado_t    estado_prox;
    logic [7:0] timer;
    logic       garrafa_s;
    logic       nivel_s;

    sincronizador u_sinc_garrafa (
        .clk   (clk),
        .reset (reset),
        .d     (sensor_garrafa),
        .q     (garrafa_s)
    );

    sincronizador u_sinc_nivel (
        .clk   (clk),
        .reset (reset),
        .d     (sensor_nivel),
        .q     (nivel_s)
    );

    // Level wins over timeout; start is ignored mid-fill so a bottle is never
    // left half full.
    always_comb begin
        estado_prox = estado;
        case (estado)
            PARADO:
                if (start && !alarme_vedacao) estado_prox = ESTEIRA;
            ESTEIRA:
                if (!start || alarme_vedacao) estado_prox = PARADO;
                else if (garrafa_s)           estado_prox = ENCHENDO;
            ENCHENDO:
                if (nivel_s)                  estado_prox = TRANSFERE;
                else if (timer == TIMER_MAX)  estado_prox = ERRO;
            TRANSFERE:
                if (done_vedacao)
                    estado_prox = (start && !alarme_vedacao) ? ESTEIRA : PARADO;
            ERRO:
                if (!start) estado_prox = PARADO;
            default:
                estado_prox = PARADO;
        endcase
    end

    // Outputs are registered from the next state so they always match the
    // state register; the timer sits at 0 outside ENCHENDO, clearing on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado            <= PARADO;
            timer             <= 8'd0;
            garrafas_cheias   <= 8'd0;
            motor             <= 1'b0;
            valvula           <= 1'b0;
            gar_pronta        <= 1'b0;
            alarme_enchimento <= 1'b0;
        end else begin
            estado <= estado_prox;
            {motor, valvula, gar_pronta, alarme_enchimento} <= decodifica(estado_prox);
            if (estado == ENCHENDO) timer <= timer + 8'd1;
            else                    timer <= 8'd0;
            if (estado == ENCHENDO && estado_prox == TRANSFERE)
                garrafas_cheias <= garrafas_cheias + 8'd1;
        end
    end

endmodule

// File: tb/tb_estacao_enchimento.sv
// Directed bench for the filling station: one default-timeout instance and
// one with FILL_TIMEOUT=10, both driven from the same inputs.
module tb_estacao_enchimento;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sensor_garrafa;
    logic       sensor_nivel;
    logic       done_vedacao;
    logic       alarme_vedacao;
    logic       motor, valvula, gar_pronta, alarme_enchimento;
    logic [7:0] garrafas_cheias;
    logic       motor_t, valvula_t, gar_pronta_t, alarme_enchimento_t;
    logic [7:0] garrafas_cheias_t;
    logic [3:0] outs;
    logic [3:0] outs_t;

    int n_pass   = 0;
    int n_checks = 0;

    assign outs   = {motor, valvula, gar_pronta, alarme_enchimento};
    assign outs_t = {motor_t, valvula_t, gar_pronta_t, alarme_enchimento_t};

    estacao_enchimento dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .sensor_garrafa    (sensor_garrafa),
        .sensor_nivel      (sensor_nivel),
        .done_vedacao      (done_vedacao),
        .alarme_vedacao    (alarme_vedacao),
        .motor             (motor),
        .valvula           (valvula),
        .gar_pronta        (gar_pronta),
        .alarme_enchimento (alarme_enchimento),
        .garrafas_cheias   (garrafas_cheias)
    );

    estacao_enchimento #(.FILL_TIMEOUT(10)) dut_t (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .sensor_garrafa    (sensor_garrafa),
        .sensor_nivel      (sensor_nivel),
        .done_vedacao      (done_vedacao),
        .alarme_vedacao    (alarme_vedacao),
        .motor             (motor_t),
        .valvula           (valvula_t),
        .gar_pronta        (gar_pronta_t),
        .alarme_enchimento (alarme_enchimento_t),
        .garrafas_cheias   (garrafas_cheias_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        start          = 1'b0;
        sensor_garrafa = 1'b0;
        sensor_nivel   = 1'b0;
        done_vedacao   = 1'b0;
        alarme_vedacao = 1'b0;
        reset          = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    // From ESTEIRA: bottle arrives, fills, is handed off, back to ESTEIRA.
    task automatic fill_cycle();
        sensor_garrafa = 1'b1;
        tick(3);
        sensor_garrafa = 1'b0;
        sensor_nivel   = 1'b1;
        tick(3);
        sensor_nivel = 1'b0;
        done_vedacao = 1'b1;
        tick();
        done_vedacao = 1'b0;
    endtask

    task automatic test_reset();
        start          = 1'b1;
        sensor_garrafa = 1'b1;
        sensor_nivel   = 1'b1;
        reset          = 1'b0;
        tick(3);
        if (outs !== 4'b0000) begin $display("[TB] FAIL reset_outs: got %b expected %b", outs, 4'b0000); end else n_pass++;
        n_checks++;
        if (garrafas_cheias !== 8'd0) begin $display("[TB] FAIL reset_count: got %0d expected 0", garrafas_cheias); end else n_pass++;
        n_checks++;
        do_reset();
        tick();
        if (outs !== 4'b0000) begin $display("[TB] FAIL reset_idle: got %b expected %b", outs, 4'b0000); end else n_pass++;
        n_checks++;
    endtask

    task automatic test_normal_cycle();
        do_reset();
        start = 1'b1;
        tick();
        if (outs !== 4'b1000) begin $display("[TB] FAIL norm_esteira: got %b expected %b", outs, 4'b1000); end else n_pass++;
        n_checks++;
        sensor_garrafa = 1'b1;
        tick(2);
        if (outs !== 4'b1000) begin $display("[TB] FAIL norm_sync_delay: got %b expected %b", outs, 4'b1000); end else n_pass++;
        n_checks++;
        tick();
        if (outs !== 4'b0100) begin $display("[TB] FAIL norm_enchendo: got %b expected %b", outs, 4'b0100); end else n_pass++;
        n_checks++;
        sensor_garrafa = 1'b0;
        start          = 1'b0;
        tick(4);
        if (outs !== 4'b0100) begin $display("[TB] FAIL norm_stop_no_abort: got %b expected %b", outs, 4'b0100); end else n_pass++;
        n_checks++;
        start        = 1'b1;
        sensor_nivel = 1'b1;
        tick(2);
        if (outs !== 4'b0100) begin $display("[TB] FAIL norm_nivel_delay: got %b expected %b", outs, 4'b0100); end else n_pass++;
        n_checks++;
        tick();
        if (outs !== 4'b0010) begin $display("[TB] FAIL norm_transfere: got %b expected %b", outs, 4'b0010); end else n_pass++;
        n_checks++;
        if (garrafas_cheias !== 8'd1) begin $display("[TB] FAIL norm_count: got %0d expected 1", garrafas_cheias); end else n_pass++;
        n_checks++;
        sensor_nivel = 1'b0;
        tick(3);
        if (outs !== 4'b0010) begin $display("[TB] FAIL norm_hold_transfere: got %b expected %b", outs, 4'b0010); end else n_pass++;
        n_checks++;
        done_vedacao = 1'b1;
        tick();
        done_vedacao = 1'b0;
        if (outs !== 4'b1000) begin $display("[TB] FAIL norm_back_esteira: got %b expected %b", outs, 4'b1000); end else n_pass++;
        n_checks++;
    endtask

    task automatic test_timeout();
        int high;
        int n;
        do_reset();
        start = 1'b1;
        tick();
        sensor_garrafa = 1'b1;
        tick(3);
        sensor_garrafa = 1'b0;
        high = 0;
        n    = 0;
        while (outs_t[2] === 1'b1 && n < 50) begin
            high++;
            tick();
            n++;
        end
        if (high !== 10) begin $display("[TB] FAIL tmo_valve_cycles: got %0d expected 10", high); end else n_pass++;
        n_checks++;
        if (outs_t !== 4'b0001) begin $display("[TB] FAIL tmo_alarm: got %b expected %b", outs_t, 4'b0001); end else n_pass++;
        n_checks++;
        tick(5);
        if (outs_t !== 4'b0001) begin $display("[TB] FAIL tmo_alarm_hold: got %b expected %b", outs_t, 4'b0001); end else n_pass++;
        n_checks++;
        start = 1'b0;
        tick();
        if (outs_t !== 4'b0000) begin $display("[TB] FAIL tmo_clear: got %b expected %b", outs_t, 4'b0000); end else n_pass++;
        n_checks++;
        if (garrafas_cheias_t !== 8'd0) begin $display("[TB] FAIL tmo_count: got %0d expected 0", garrafas_cheias_t); end else n_pass++;
        n_checks++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        start = 1'b1;
        tick();
        sensor_garrafa = 1'b1;
        tick(3);
        sensor_garrafa = 1'b0;
        // Timer is 0 now; synchronized level lands on the edge where timer is 9.
        tick(7);
        sensor_nivel = 1'b1;
        tick(2);
        if (outs_t !== 4'b0100) begin $display("[TB] FAIL sim_still_filling: got %b expected %b", outs_t, 4'b0100); end else n_pass++;
        n_checks++;
        tick();
        if (outs_t !== 4'b0010) begin $display("[TB] FAIL sim_level_wins: got %b expected %b", outs_t, 4'b0010); end else n_pass++;
        n_checks++;
        if (garrafas_cheias_t !== 8'd1) begin $display("[TB] FAIL sim_count: got %0d expected 1", garrafas_cheias_t); end else n_pass++;
        n_checks++;
        sensor_nivel = 1'b0;
    endtask

    task automatic test_capping_alarm();
        do_reset();
        start = 1'b1;
        tick();
        alarme_vedacao = 1'b1;
        tick();
        if (outs !== 4'b0000) begin $display("[TB] FAIL cap_esteira_stop: got %b expected %b", outs, 4'b0000); end else n_pass++;
        n_checks++;
        tick(2);
        if (outs !== 4'b0000) begin $display("[TB] FAIL cap_parado_hold: got %b expected %b", outs, 4'b0000); end else n_pass++;
        n_checks++;
        alarme_vedacao = 1'b0;
        tick();
        sensor_garrafa = 1'b1;
        tick(3);
        sensor_garrafa = 1'b0;
        sensor_nivel   = 1'b1;
        tick(3);
        sensor_nivel   = 1'b0;
        alarme_vedacao = 1'b1;
        tick(4);
        if (outs !== 4'b0010) begin $display("[TB] FAIL cap_transfere_hold: got %b expected %b", outs, 4'b0010); end else n_pass++;
        n_checks++;
        alarme_vedacao = 1'b0;
        done_vedacao   = 1'b1;
        tick();
        done_vedacao = 1'b0;
        if (outs !== 4'b1000) begin $display("[TB] FAIL cap_release: got %b expected %b", outs, 4'b1000); end else n_pass++;
        n_checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        start = 1'b1;
        tick();
        for (int i = 0; i < 255; i++) fill_cycle();
        if (garrafas_cheias !== 8'd255) begin $display("[TB] FAIL wrap_255: got %0d expected 255", garrafas_cheias); end else n_pass++;
        n_checks++;
        fill_cycle();
        if (garrafas_cheias !== 8'd0) begin $display("[TB] FAIL wrap_zero: got %0d expected 0", garrafas_cheias); end else n_pass++;
        n_checks++;
        if (outs !== 4'b1000) begin $display("[TB] FAIL wrap_state: got %b expected %b", outs, 4'b1000); end else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        start = 1'b1;
        tick();
        fill_cycle();
        sensor_garrafa = 1'b1;
        tick(3);
        sensor_garrafa = 1'b0;
        if (outs !== 4'b0100 || garrafas_cheias !== 8'd1) begin
            $display("[TB] FAIL rmf_setup: got %b/%0d expected %b/1", outs, garrafas_cheias, 4'b0100);
        end else n_pass++;
        n_checks++;
        #2;
        reset = 1'b0;
        #1;
        if (valvula !== 1'b0) begin $display("[TB] FAIL rmf_valve_async: got %b expected 0", valvula); end else n_pass++;
        n_checks++;
        if (garrafas_cheias !== 8'd0) begin $display("[TB] FAIL rmf_count: got %0d expected 0", garrafas_cheias); end else n_pass++;
        n_checks++;
        reset = 1'b1;
        #1;
        if (outs !== 4'b0000) begin $display("[TB] FAIL rmf_parado: got %b expected %b", outs, 4'b0000); end else n_pass++;
        n_checks++;
        tick();
        if (outs !== 4'b1000) begin $display("[TB] FAIL rmf_resume: got %b expected %b", outs, 4'b1000); end else n_pass++;
        n_checks++;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_normal_cycle();
        test_timeout();
        test_simultaneous();
        test_capping_alarm();
        test_wrap();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/estacao_enchimento.md
ESTACAO_ENCHIMENTO -- requirements
Module: estacao_enchimento

Interface
REQ-001 SHALL have parameter FILL_TIMEOUT, default 100, maximum fill duration in clk cycles, legal range 2..255.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port start  input  1  operator run switch; 1 = run, 0 = stop request.
REQ-005 SHALL have port sensor_garrafa  input  1  asynchronous; 1 = empty bottle under fill nozzle.
REQ-006 SHALL have port sensor_nivel  input  1  asynchronous; 1 = bottle filled to level.
REQ-007 SHALL have port done_vedacao  input  1  capping stage done; 1 = bottle taken and sealed.
REQ-008 SHALL have port alarme_vedacao  input  1  capping stage alarm; 1 = capping stage cannot accept bottles.
REQ-009 SHALL have port motor  output  1  conveyor motor enable.
REQ-010 SHALL have port valvula  output  1  fill valve open.
REQ-011 SHALL have port gar_pronta  output  1  filled bottle presented to capping stage (drives its gar/pos inputs).
REQ-012 SHALL have port alarme_enchimento  output  1  fill timeout alarm.
REQ-013 SHALL have port garrafas_cheias  output  8  count of bottles filled since reset.

Function
REQ-014 SHALL pass sensor_garrafa and sensor_nivel through 2-flop synchronizers; FSM uses only synchronized values (raw delayed by 2 clk).
REQ-015 SHALL implement a Moore FSM with states PARADO, ESTEIRA, ENCHENDO, TRANSFERE, ERRO; outputs decoded from registered state only.
REQ-016 Outputs per state SHALL be: PARADO all 0; ESTEIRA motor=1; ENCHENDO valvula=1; TRANSFERE gar_pronta=1; ERRO alarme_enchimento=1; unlisted outputs 0.
REQ-017 PARADO SHALL go to ESTEIRA when start=1 and alarme_vedacao=0, else remain.
REQ-018 ESTEIRA SHALL go to PARADO when start=0 or alarme_vedacao=1 (priority), else to ENCHENDO when synchronized sensor_garrafa=1.
REQ-019 Entry to ENCHENDO SHALL clear an 8-bit timer to 0; timer SHALL increment once per cycle while in ENCHENDO.
REQ-020 ENCHENDO SHALL go to TRANSFERE when synchronized sensor_nivel=1; else to ERRO when timer = FILL_TIMEOUT-1; level has priority when both occur in the same cycle.
REQ-021 start=0 during ENCHENDO SHALL NOT abort the fill.
REQ-022 garrafas_cheias SHALL increment by 1 on each ENCHENDO->TRANSFERE transition, wrapping 255->0.
REQ-023 TRANSFERE SHALL hold gar_pronta=1 until done_vedacao=1, then go to ESTEIRA if start=1 and alarme_vedacao=0, else PARADO.
REQ-024 alarme_vedacao=1 during TRANSFERE SHALL keep the FSM in TRANSFERE (bottle stays presented).
REQ-025 ERRO SHALL be left only via start=0, going to PARADO; alarme_enchimento SHALL remain 1 until then.
REQ-026 Unused state encodings SHALL return to PARADO on the next clock.

Reset
REQ-027 While reset=0 SHALL force: state PARADO, timer 0, garrafas_cheias 0, synchronizer flops 0, all outputs 0, independent of clk.
REQ-028 Reset asserted mid-fill SHALL close valvula immediately (asynchronously); release SHALL resume from PARADO.

Structure
REQ-029 State encodings and FILL_TIMEOUT default SHALL reside in the shared system constants include used by the other MEF blocks.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named sincronizador, instantiated once per sensor.

Verification
REQ-031 Normal cycle: start=1, sensor_garrafa 1 at cycle 5 -> ENCHENDO at cycle 8; sensor_nivel 1 at cycle 20 -> TRANSFERE at 23, garrafas_cheias=1; done_vedacao at 30 -> ESTEIRA at 31.
REQ-032 Timeout: FILL_TIMEOUT=10, sensor_nivel held 0 -> valvula high exactly 10 cycles, then alarme_enchimento=1; start=0 -> PARADO, alarme 0.
REQ-033 Simultaneous: sensor_nivel synchronized value reaches 1 in the cycle timer=FILL_TIMEOUT-1 -> TRANSFERE, no alarm.
REQ-034 Wrap: 256 complete cycles -> garrafas_cheias returns to 0.
REQ-035 Capping alarm: alarme_vedacao=1 in ESTEIRA -> PARADO next cycle; in TRANSFERE -> gar_pronta stays 1 until done_vedacao.
REQ-036 Reset mid-fill: reset=0 in ENCHENDO -> valvula 0 without clock edge, garrafas_cheias 0; release with start=1 -> ESTEIRA one cycle later.
